key_pulse_bank: RTL and testbench

Parametrised multi-channel button front end that replaces the single-key falling-edge pulse generator used on the DE1-SoC demo tops. Each channel has the following:
- synchroniser
- counter-based debouncer
- one-cycle press and release pulses
- optional per-channel auto-repeat

It sits between the board KEY/SW pins and the demo control logic (load/execute/step strobes for the ALU and Fibonacci FSM).

---
 rtl/key_pulse_pkg.sv | 28 ++
 rtl/key_debounce_channel.sv | 144 ++++++++++++++
 rtl/key_pulse_bank.sv | 67 ++++++
 tb/tb_key_pulse_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg
// Shared constants and helpers for the key_pulse_bank button front end.
//   DEF_DEBOUNCE_50MHZ : 20 ms debounce window at 50 MHz
//   DEF_REPEAT_DELAY   : 0.5 s from press to first auto-repeat at 50 MHz
//   DEF_REPEAT_RATE    : 0.1 s between subsequent auto-repeats at 50 MHz
//   rep_phase_e        : auto-repeat phase (initial delay, then steady rate)
//   cnt_width()        : bits needed to hold a counter value 0..max_count
package key_pulse_pkg;

  localparam int DEF_DEBOUNCE_50MHZ = 1000000;
  localparam int DEF_REPEAT_DELAY   = 25000000;
  localparam int DEF_REPEAT_RATE    = 5000000;

  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } rep_phase_e;

  // Width of a counter that must represent every value from 0 up to max_count.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      cnt_width = 1;
    end else begin
      cnt_width = $clog2(max_count + 1);
    end
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel
// One button channel: input synchroniser, counter debouncer, one-cycle
// press/release strobes and optional auto-repeat.
// Ports:
//   clk           in  system clock
//   reset         in  asynchronous active-high reset
//   key_in        in  raw asynchronous key level
//   repeat_en     in  auto-repeat enable (quasi-static)
//   key_state     out debounced level, 1 = pressed
//   press_pulse   out registered strobe on press and on each repeat
//   release_pulse out registered strobe on release
//   press_next    out next-state value of press_pulse (lets the top register
//                     an OR that lines up with press_pulse)
module key_debounce_channel
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_next
);

  localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W    = cnt_width(RPT_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO    = DB_W'(0);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(1);
  localparam logic [RP_W-1:0] RP_ZERO    = RP_W'(0);

  // Raw level that means "not pressed"; the synchroniser resets to it so
  // reset release never looks like an edge.
  localparam logic INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   pressed_sync_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic [DB_W-1:0]        db_cnt_next_s;
  logic                   toggle_s;
  logic [RP_W-1:0]        rpt_cnt_r;
  logic [RP_W-1:0]        rpt_cnt_next_s;
  rep_phase_e             rpt_phase_r;
  rep_phase_e             rpt_phase_next_s;
  logic                   rpt_fire_s;
  logic                   release_next_s;
  logic                   key_state_r;
  logic                   press_pulse_r;
  logic                   release_pulse_r;

  assign pressed_sync_s = sync_r[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Debounce: count consecutive disagreement cycles, flip on the terminal count.
  always_comb begin
    db_cnt_next_s = db_cnt_r;
    toggle_s      = 1'b0;
    if (pressed_sync_s == key_state_r) begin
      db_cnt_next_s = DB_ZERO;
    end else if (db_cnt_r == DB_LAST) begin
      toggle_s      = 1'b1;
      db_cnt_next_s = DB_ZERO;
    end else begin
      db_cnt_next_s = db_cnt_r + DB_ONE;
    end
  end

  // Auto-repeat: a release toggle cancels without firing, so the release
  // edge can never carry a press strobe.
  always_comb begin
    rpt_cnt_next_s   = rpt_cnt_r;
    rpt_phase_next_s = rpt_phase_r;
    rpt_fire_s       = 1'b0;
    if (toggle_s || !key_state_r || !repeat_en) begin
      rpt_cnt_next_s   = RP_ZERO;
      rpt_phase_next_s = PH_DELAY;
    end else begin
      case (rpt_phase_r)
        PH_DELAY: begin
          if (rpt_cnt_r == DELAY_LAST) begin
            rpt_fire_s       = 1'b1;
            rpt_cnt_next_s   = RP_ZERO;
            rpt_phase_next_s = PH_RATE;
          end else begin
            rpt_cnt_next_s = rpt_cnt_r + RP_ONE;
          end
        end
        PH_RATE: begin
          if (rpt_cnt_r == RATE_LAST) begin
            rpt_fire_s     = 1'b1;
            rpt_cnt_next_s = RP_ZERO;
          end else begin
            rpt_cnt_next_s = rpt_cnt_r + RP_ONE;
          end
        end
        default: begin
          rpt_cnt_next_s   = RP_ZERO;
          rpt_phase_next_s = PH_DELAY;
        end
      endcase
    end
  end

  assign press_next     = (toggle_s & ~key_state_r) | rpt_fire_s;
  assign release_next_s = toggle_s & key_state_r;

  // Channel state registers: synchroniser, counters, debounced level, strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r          <= {SYNC_STAGES{INACTIVE}};
      db_cnt_r        <= DB_ZERO;
      rpt_cnt_r       <= RP_ZERO;
      rpt_phase_r     <= PH_DELAY;
      key_state_r     <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
    end else begin
      sync_r          <= {sync_r[SYNC_STAGES-2:0], key_in};
      db_cnt_r        <= db_cnt_next_s;
      rpt_cnt_r       <= rpt_cnt_next_s;
      rpt_phase_r     <= rpt_phase_next_s;
      key_state_r     <= key_state_r ^ toggle_s;
      press_pulse_r   <= press_next;
      release_pulse_r <= release_next_s;
    end
  end

  assign key_state     = key_state_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;

endmodule

// File: rtl/key_pulse_bank.sv
// key_pulse_bank
// Multi-channel debounced button front end with press/release strobes and
// per-channel auto-repeat, for the DE1-SoC demo tops.
// Ports:
//   clk           in  system clock (CLOCK_50)
//   reset         in  asynchronous active-high reset
//   key_in        in  [N_KEYS] raw asynchronous key/switch levels
//   repeat_en     in  [N_KEYS] per-channel auto-repeat enable
//   key_state     out [N_KEYS] debounced level, 1 = pressed
//   press_pulse   out [N_KEYS] one-cycle press / repeat strobe
//   release_pulse out [N_KEYS] one-cycle release strobe
//   any_press     out registered OR of press_pulse, aligned with it
module key_pulse_bank
  import key_pulse_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              any_press
);

  logic [N_KEYS-1:0] press_next_s;
  logic              any_press_r;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in[g]),
      .repeat_en    (repeat_en[g]),
      .key_state    (key_state[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .press_next   (press_next_s[g])
    );
  end

  // Registering the OR of next-state strobes keeps any_press cycle-aligned
  // with the per-channel press_pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press_r <= 1'b0;
    end else begin
      any_press_r <= |press_next_s;
    end
  end

  assign any_press = any_press_r;

endmodule

// File: tb/tb_key_pulse_bank.sv
// tb_key_pulse_bank
// Directed bench for key_pulse_bank. Expected strobes are scheduled into a
// queue (keyed by clock edge number) when stimulus is applied; a negedge
// monitor pops them and compares every cycle. A second instance with a
// one-cycle debounce window covers the minimum-debounce case.
module tb_key_pulse_bank;

  typedef struct {
    int         cyc;
    logic [3:0] prs;
    logic [3:0] rel;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] repeat_en;
  logic [3:0] key_state;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       any_press;

  logic [3:0] key_in1;
  logic [3:0] repeat_en1;
  logic [3:0] key_state1;
  logic [3:0] press_pulse1;
  logic [3:0] release_pulse1;
  logic       any_press1;

  int   checks;
  int   errors;
  int   edge_cnt;
  logic mon_en;
  logic [3:0] exp_state;
  exp_t q[$];

  key_pulse_bank #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .repeat_en(repeat_en),
    .key_state(key_state), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .any_press(any_press)
  );

  key_pulse_bank #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(10), .REPEAT_RATE(5)
  ) dut1 (
    .clk(clk), .reset(reset), .key_in(key_in1), .repeat_en(repeat_en1),
    .key_state(key_state1), .press_pulse(press_pulse1),
    .release_pulse(release_pulse1), .any_press(any_press1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic push(input int cyc, input logic [3:0] p, input logic [3:0] r);
    exp_t e;
    e.cyc = cyc;
    e.prs = p;
    e.rel = r;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: outputs after edge N must match events scheduled for N.
  initial begin
    logic [3:0] exp_p;
    logic [3:0] exp_r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_p = 4'h0;
        exp_r = 4'h0;
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
          exp_p = exp_p | q[0].prs;
          exp_r = exp_r | q[0].rel;
          void'(q.pop_front());
        end
        exp_state = (exp_state | exp_p) & ~exp_r;
        chk("press_pulse", {28'h0, press_pulse}, {28'h0, exp_p});
        chk("release_pulse", {28'h0, release_pulse}, {28'h0, exp_r});
        chk("any_press", {31'h0, any_press}, {31'h0, |exp_p});
        chk("key_state", {28'h0, key_state}, {28'h0, exp_state});
      end
    end
  end

  initial begin
    int s;
    checks     = 0;
    errors     = 0;
    mon_en     = 1'b0;
    exp_state  = 4'h0;
    reset      = 1'b1;
    key_in     = 4'hF;
    repeat_en  = 4'h0;
    key_in1    = 4'hF;
    repeat_en1 = 4'h0;

    // 1. Reset and idle
    tick(3);
    chk("rst_key_state", {28'h0, key_state}, 32'h0);
    chk("rst_press", {28'h0, press_pulse}, 32'h0);
    chk("rst_release", {28'h0, release_pulse}, 32'h0);
    chk("rst_any", {31'h0, any_press}, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(50);

    // 1b. Asynchronous reset while channel 0 is pressed
    key_in[0] = 1'b0;
    s = edge_cnt + 1;
    push(s + 5, 4'h1, 4'h0);
    tick(10);
    chk("pre_arst_state0", {31'h0, key_state[0]}, 32'h1);
    #3;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("arst_key_state", {28'h0, key_state}, 32'h0);
    chk("arst_press", {28'h0, press_pulse}, 32'h0);
    chk("arst_release", {28'h0, release_pulse}, 32'h0);
    chk("arst_any", {31'h0, any_press}, 32'h0);
    q.delete();
    exp_state = 4'h0;
    tick(1);
    reset = 1'b0;
    // key still held through reset: a normal press follows
    s = edge_cnt + 1;
    push(s + 5, 4'h1, 4'h0);
    mon_en = 1'b1;
    tick(8);
    key_in[0] = 1'b1;
    s = edge_cnt + 1;
    push(s + 5, 4'h0, 4'h1);
    tick(10);

    // 2. Clean press/release on channel 1
    key_in[1] = 1'b0;
    s = edge_cnt + 1;
    push(s + 5, 4'h2, 4'h0);
    tick(20);
    key_in[1] = 1'b1;
    s = edge_cnt + 1;
    push(s + 5, 4'h0, 4'h2);
    tick(10);

    // 3. Bounce rejection on channel 2, then a real press
    for (int i = 0; i < 3; i++) begin
      key_in[2] = 1'b0;
      tick(3);
      key_in[2] = 1'b1;
      tick(1);
    end
    key_in[2] = 1'b0;
    s = edge_cnt + 1;
    push(s + 5, 4'h4, 4'h0);
    tick(8);
    key_in[2] = 1'b1;
    s = edge_cnt + 1;
    push(s + 5, 4'h0, 4'h4);
    tick(10);

    // 4. Auto-repeat on channel 0: press at c, repeats c+10/15/20, release c+22
    repeat_en[0] = 1'b1;
    key_in[0] = 1'b0;
    s = edge_cnt + 1;
    push(s + 5, 4'h1, 4'h0);
    push(s + 15, 4'h1, 4'h0);
    push(s + 20, 4'h1, 4'h0);
    push(s + 25, 4'h1, 4'h0);
    tick(22);
    key_in[0] = 1'b1;
    push(s + 27, 4'h0, 4'h1);
    tick(15);

    // 4b. Same hold with repeat disabled: single press only
    repeat_en[0] = 1'b0;
    key_in[0] = 1'b0;
    s = edge_cnt + 1;
    push(s + 5, 4'h1, 4'h0);
    tick(22);
    key_in[0] = 1'b1;
    push(s + 27, 4'h0, 4'h1);
    tick(15);

    // 5. All channels at once
    key_in = 4'h0;
    s = edge_cnt + 1;
    push(s + 5, 4'hF, 4'h0);
    tick(10);
    key_in = 4'hF;
    s = edge_cnt + 1;
    push(s + 5, 4'h0, 4'hF);
    tick(10);

    // 6. One-cycle debounce window: one-cycle low on channel 3
    key_in1[3] = 1'b0;
    tick(1);
    key_in1[3] = 1'b1;
    chk("db1_press_e0", {28'h0, press_pulse1}, 32'h0);
    tick(1);
    chk("db1_press_e1", {28'h0, press_pulse1}, 32'h0);
    tick(1);
    chk("db1_press_e2", {28'h0, press_pulse1}, 32'h8);
    chk("db1_state_e2", {28'h0, key_state1}, 32'h8);
    chk("db1_any_e2", {31'h0, any_press1}, 32'h1);
    chk("db1_release_e2", {28'h0, release_pulse1}, 32'h0);
    tick(1);
    chk("db1_press_e3", {28'h0, press_pulse1}, 32'h0);
    chk("db1_release_e3", {28'h0, release_pulse1}, 32'h8);
    chk("db1_state_e3", {28'h0, key_state1}, 32'h0);
    tick(1);
    chk("db1_release_e4", {28'h0, release_pulse1}, 32'h0);

    mon_en = 1'b0;
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
